alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Two-entry registered operand buffer directly upstream of the 32-bit bitwise units (XOR/AND/OR) and adder.
//  Accepts {A, B, op} from the decode stage over a valid/ready handshake.
//  Presents one held operand set to the ALU datapath; retires it when the result stage accepts it.
//  Decouples decode stalls from the ALU and breaks the decode->ALU timing path.
// PARAMETERS
//  WIDTH     32   operand width in bits; A and B are both WIDTH
//  OP_W      3    opcode width, passed through unmodified
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      upstream offers {in_a, in_b, in_op}
//  in_ready   out  1      buffer can accept this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   OP_W   ALU opcode
//  in_par     in   2      even parity of {in_b, in_a}: [1]=B, [0]=A; used only with PARITY_CHECK_EN
//  A          out  WIDTH  operand A to ALU (head entry)
//  B          out  WIDTH  operand B to ALU (head entry)
//  op         out  OP_W   opcode to ALU (head entry)
//  out_valid  out  1      A/B/op hold a valid entry
//  out_ready  in   1      downstream consumes head entry this cycle
//  count      out  2      occupancy 0..2
//  par_err    out  1      sticky parity error flag
//  par_clr    in   1      clears par_err
// BEHAVIOUR
//  - Reset (reset_n low, async): count=0, out_valid=0, in_ready=1, A=B=0, op=0, par_err=0; both entries invalid.
//    Reset mid-transfer discards all held entries.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same rising edge.
//  - in_ready = (count != 2), decoded from the registered count. No combinational path from out_ready to in_ready.
//  - Latency: an entry pushed at edge N appears on A/B/op with out_valid=1 after edge N if the buffer was empty;
//    otherwise it appears after the edge that pops the entry ahead of it.
//  - State transitions:
//      EMPTY(0) -push-> ONE
//      ONE(1)   -push&!pop-> TWO;  -pop&!push-> EMPTY;  -push&pop-> ONE, new entry moves to head
//      TWO(2)   -pop-> ONE, second entry moves to head; no push is possible
//  - Strict FIFO order; each entry is delivered exactly once. Outputs are driven only from registers.
//  - A/B/op stay stable while out_valid=1 and out_ready=0.
//  - When the buffer goes empty, A/B/op hold their last values (not zeroed); out_valid=0.
//  - in_a/in_b/in_op are don't-care while in_valid=0.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//    - On push, check (^in_a)==in_par[0] and (^in_b)==in_par[1].
//    - On mismatch the entry is dropped: count unchanged, or count-1 if a pop occurs the same edge.
//      par_err is set the next cycle.
//    - par_err clears on par_clr. If set and clear coincide, set wins.
//  PARITY_CHECK_EN undefined:
//    - in_par and par_clr are ignored; par_err is tied 0; every push is stored.
// TESTING
//  1. Reset: reset_n=0 mid-stream with count=2 -> count=0, out_valid=0, in_ready=1, A=B=0 immediately.
//  2. Single pass: push A=32'hFFFF0000, B=32'h0F0F0F0F, op=3'd2 into an empty buffer, out_ready=1
//     -> out_valid=1 on the next cycle with those values, popped the following edge; count 0->1->0.
//  3. Backpressure: out_ready=0, push 3 entries back-to-back -> in_ready=0 after 2; count=2;
//     A/B hold entry 1 unchanged; entry 3 is not accepted.
//  4. Simultaneous push/pop at count=1 for 100 cycles, random data -> count stays 1;
//     output sequence equals input sequence, delayed by one entry.
//  5. Drain order: fill with entries X, then Y; raise out_ready -> X then Y on consecutive cycles;
//     out_valid=0 afterward with A/B still holding Y.
//  6. PARITY_CHECK_EN: push A=32'h1 with in_par=2'b00 -> entry dropped, count unchanged, par_err=1;
//     pulse par_clr -> par_err=0. Without the macro the same stimulus is stored and par_err=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Two-entry {A,B,op} operand buffer ahead of the ALU; optional drop-on-bad-parity via PARITY_CHECK_EN.
// Latency: one cycle into an empty buffer, otherwise the entry waits behind the head.
// Backpressure: in_ready comes from registered occupancy only, with no path from out_ready.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [1:0]       in_par,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic             par_err,
  input  logic             par_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
  } operand_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t   state_q, state_d;
  operand_t head_q, tail_q, in_ent;
  logic     push, pop, store, par_ok;
  logic     load_head_in, load_head_tail, load_tail;

  assign in_ent    = '{a: in_a, b: in_b, op: in_op};
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign store     = push & par_ok;

  assign A  = head_q.a;
  assign B  = head_q.b;
  assign op = head_q.op;

`ifdef PARITY_CHECK_EN
  logic par_err_q;

  assign par_ok  = ((^in_a) == in_par[0]) && ((^in_b) == in_par[1]);
  assign par_err = par_err_q;

  // A new error outranks a coincident clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else if (push && !par_ok) begin
      par_err_q <= 1'b1;
    end else if (par_clr) begin
      par_err_q <= 1'b0;
    end
  end
`else
  logic unused_par;

  assign par_ok     = 1'b1;
  assign par_err    = 1'b0;
  assign unused_par = ^{in_par, par_clr};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (store) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (store && pop) begin
          load_head_in = 1'b1;
        end else if (store) begin
          state_d   = TWO;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Head keeps its last contents when the buffer drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= in_ent;
      end else if (load_head_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= in_ent;
      end
    end
  end

endmodule
